// File: rtl/sccb_init_sequencer.sv
// sccb_init_sequencer: walks a {reg,value} ROM table and issues each entry as an SCCB write via COREI2C over APB
module sccb_init_sequencer #(
   parameter int         NUM_ENTRIES   = 64,
   parameter int         ADDR_W        = 8,
   parameter logic [7:0] SLAVE_ADDR    = 8'h42,
   parameter logic [2:0] CR_SEL        = 3'b000,
   parameter int         CYCLES_PER_MS = 30000,
   parameter int         INT_TIMEOUT   = 65535,
   parameter int         STOP_GAP      = 300,
   parameter bit         IGNORE_NACK   = 1'b1
) (
   input  logic              PCLK,
   input  logic              PRESETN,
   input  logic              start,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [15:0]       rom_data,
   output logic              i2c_psel,
   output logic              i2c_penable,
   output logic              i2c_pwrite,
   output logic [8:0]        i2c_paddr,
   output logic [7:0]        i2c_pwdata,
   input  logic [7:0]        i2c_prdata,
   input  logic              i2c_int,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [7:0]        err_status,
   output logic [ADDR_W-1:0] entry_idx
);
   localparam int CNT_W = $clog2(255 * CYCLES_PER_MS + INT_TIMEOUT + STOP_GAP + 4);
   localparam logic [7:0] BASE = {CR_SEL[2], 1'b1, 4'b0000, CR_SEL[1:0]};
   localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_TWO = CNT_W'(2);
   localparam logic [CNT_W-1:0] C_TMO = CNT_W'(INT_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] C_GAP = CNT_W'(STOP_GAP - 1);
   localparam logic [CNT_W-1:0] C_CPM = CNT_W'(CYCLES_PER_MS);
   typedef enum logic [3:0] {
      S_IDLE, S_ENABLE, S_FETCH, S_DELAY, S_START, S_WAIT, S_READ,
      S_CHECK, S_DATA, S_CLR, S_STOP, S_GAP, S_NEXT, S_ABORT
   } state_t;
   state_t            r_state, w_next;
   logic [CNT_W-1:0]  r_cnt, w_dly;
   logic [ADDR_W-1:0] r_idx;
   logic [7:0]        r_reg, r_val, r_stat, r_err_st, w_fail_code, w_byte;
   logic [1:0]        r_byte;
   logic              r_done, r_error, w_apb, w_go, w_ok, w_fail, w_last;
   // r_cnt doubles as the APB phase: 0 setup, 1 access, 2 mandatory idle
   always_comb begin
      w_go        = start && !r_done;
      w_last      = r_idx == ADDR_W'(NUM_ENTRIES - 1);
      w_dly       = CNT_W'(r_val) * C_CPM;
      w_ok        = r_byte == 2'd0 ? (r_stat == 8'h08 || r_stat == 8'h10) :
                    r_byte == 2'd1 ? (r_stat == 8'h18 || (IGNORE_NACK && r_stat == 8'h20)) :
                                     (r_stat == 8'h28 || (IGNORE_NACK && r_stat == 8'h30));
      w_byte      = r_byte == 2'd1 ? SLAVE_ADDR : r_byte == 2'd2 ? r_reg : r_val;
      w_fail      = 1'b0;
      w_fail_code = r_stat;
      w_next      = r_state;
      case (r_state)
         S_IDLE:   if (w_go) w_next = S_ENABLE;
         S_ENABLE: if (r_cnt == C_TWO) w_next = S_FETCH;
         S_FETCH:  if (r_cnt == C_ONE) w_next = rom_data[15:8] != 8'hFF ? S_START :
                                                rom_data[7:0] != 8'h00 ? S_DELAY : S_NEXT;
         S_DELAY:  if (r_cnt == w_dly - C_ONE) w_next = S_NEXT;
         S_START:  if (r_cnt == C_TWO) w_next = S_WAIT;
         S_WAIT: begin
            if (i2c_int) w_next = S_READ;
            else if (r_cnt == C_TMO) begin
               w_next      = S_ABORT;
               w_fail      = 1'b1;
               w_fail_code = 8'hEE;
            end
         end
         S_READ:   if (r_cnt == C_TWO) w_next = S_CHECK;
         S_CHECK: begin
            if (w_ok) w_next = r_byte == 2'd3 ? S_STOP : S_DATA;
            else begin
               w_fail = 1'b1;
               w_next = r_stat == 8'h38 ? S_IDLE : S_ABORT;
            end
         end
         S_DATA:   if (r_cnt == C_TWO) w_next = S_CLR;
         S_CLR:    if (r_cnt == C_TWO) w_next = S_WAIT;
         S_STOP:   if (r_cnt == C_TWO) w_next = S_GAP;
         S_GAP:    if (r_cnt == C_GAP) w_next = S_NEXT;
         S_NEXT:   w_next = w_last ? S_IDLE : S_FETCH;
         S_ABORT:  if (r_cnt == C_TWO) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
      w_apb       = r_state inside {S_ENABLE, S_START, S_READ, S_DATA, S_CLR, S_STOP, S_ABORT};
      i2c_psel    = w_apb && r_cnt < C_TWO;
      i2c_penable = w_apb && r_cnt == C_ONE;
      i2c_pwrite  = w_apb && r_state != S_READ;
      i2c_paddr   = r_state == S_READ ? 9'h004 : r_state == S_DATA ? 9'h008 : 9'h000;
      i2c_pwdata  = !w_apb ? 8'h00 : r_state == S_START ? (BASE | 8'h20) :
                    (r_state == S_STOP || r_state == S_ABORT) ? (BASE | 8'h10) :
                    r_state == S_DATA ? w_byte : BASE;
   end
   always_ff @(posedge PCLK) begin
      if (!PRESETN) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_idx    <= '0;
         r_reg    <= '0;
         r_val    <= '0;
         r_stat   <= '0;
         r_err_st <= '0;
         r_byte   <= '0;
         r_done   <= 1'b0;
         r_error  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= (w_next != r_state || r_state == S_IDLE) ? '0 : r_cnt + C_ONE;
         r_done  <= r_state == S_NEXT && w_last;
         if (r_state == S_IDLE && w_go) begin
            r_idx    <= '0;
            r_error  <= 1'b0;
            r_err_st <= '0;
         end
         if (r_state == S_NEXT && !w_last) r_idx <= r_idx + ADDR_W'(1);
         if (r_state == S_FETCH && r_cnt == C_ONE) {r_reg, r_val} <= rom_data;
         if (r_state == S_START) r_byte <= 2'd0;
         if (r_state == S_CHECK && w_ok) r_byte <= r_byte + 2'd1;
         if (r_state == S_READ && r_cnt == C_ONE) r_stat <= i2c_prdata;
         if (w_fail) begin
            r_error  <= 1'b1;
            r_err_st <= w_fail_code;
         end
      end
   end
   assign rom_addr   = r_idx;
   assign entry_idx  = r_idx;
   assign busy       = r_state != S_IDLE;
   assign done       = r_done;
   assign error      = r_error;
   assign err_status = r_err_st;
endmodule

// File: tb/tb_sccb_init_sequencer.sv
// tb_sccb_init_sequencer: random ROM tables and status scripts checked against a per-entry transaction model
module tb_sccb_init_sequencer;
   localparam int N   = 8;
   localparam int AW  = 4;
   localparam int CPM = 10;
   localparam int TMO = 100;
   localparam logic [16:0] W_STOP = {9'h000, 8'h50};
   localparam logic [16:0] W_STA  = {9'h000, 8'h60};
   typedef struct packed {logic [16:0] w; int cyc;} wr_t;
   logic          PCLK = 1'b0, PRESETN = 1'b0, start = 1'b0;
   logic [AW-1:0] rom_addr, entry_idx;
   logic [15:0]   rom_data = 16'h0;
   logic          i2c_psel, i2c_penable, i2c_pwrite, busy, done, error;
   logic [8:0]    i2c_paddr;
   logic [7:0]    i2c_pwdata, i2c_prdata, err_status;
   logic          int_lvl = 1'b0, data_pend = 1'b0;
   logic [7:0]    stat_reg = 8'h00;
   int            int_cd = 0, cyc = 0, dones = 0, viol = 0, log_base = 0;
   int            n_checks = 0, n_fail = 0;
   logic [15:0]   rom [16];
   wr_t           log_q [$];
   logic [16:0]   exp_q [$];
   int            st_q [$];
   logic          m_err, m_done;
   logic [7:0]    m_est;
   int            m_idx;
   logic          p_sel = 1'b0, p_en = 1'b0, p_wr = 1'b0;
   logic [8:0]    p_addr = '0;
   logic [7:0]    p_wd = '0;
   int            codes [7] = '{32'h20, 32'h30, 32'h38, 32'h00, 32'h48, 32'hF8, -1};

   sccb_init_sequencer #(
      .NUM_ENTRIES(N), .ADDR_W(AW), .SLAVE_ADDR(8'h42), .CR_SEL(3'b000),
      .CYCLES_PER_MS(CPM), .INT_TIMEOUT(TMO), .STOP_GAP(6), .IGNORE_NACK(1'b0)
   ) dut (
      .PCLK(PCLK), .PRESETN(PRESETN), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
      .i2c_psel(i2c_psel), .i2c_penable(i2c_penable), .i2c_pwrite(i2c_pwrite),
      .i2c_paddr(i2c_paddr), .i2c_pwdata(i2c_pwdata), .i2c_prdata(i2c_prdata),
      .i2c_int(int_lvl), .busy(busy), .done(done), .error(error),
      .err_status(err_status), .entry_idx(entry_idx)
   );

   always #5 PCLK = ~PCLK;
   always @(posedge PCLK) rom_data <= rom[rom_addr];
   assign i2c_prdata = i2c_paddr == 9'h004 ? stat_reg : 8'h00;

   // COREI2C stand-in: SI rises a random delay after STA or after the SI-clear that follows a DATA write
   always @(posedge PCLK) begin : core
      int s;
      cyc <= cyc + 1;
      if (!PRESETN) begin
         int_lvl   <= 1'b0;
         int_cd    <= 0;
         data_pend <= 1'b0;
      end else if (i2c_psel && i2c_penable && i2c_pwrite) begin
         log_q.push_back('{w: {i2c_paddr, i2c_pwdata}, cyc: cyc});
         if (i2c_paddr == 9'h000) begin
            int_lvl   <= 1'b0;
            data_pend <= 1'b0;
            int_cd    <= 0;
            if ((i2c_pwdata[5] || data_pend) && st_q.size() > 0) begin
               s = st_q.pop_front();
               if (s >= 0) begin
                  stat_reg <= 8'(s);
                  int_cd   <= int'($urandom_range(12, 1));
               end
            end
         end else if (i2c_paddr == 9'h008) data_pend <= 1'b1;
      end else if (int_cd > 0) begin
         int_cd <= int_cd - 1;
         if (int_cd == 1) int_lvl <= 1'b1;
      end
   end

   always @(negedge PCLK) begin
      if (done) dones <= dones + 1;
      if (PRESETN) begin
         if (i2c_penable && (!i2c_psel || !(p_sel && !p_en) || i2c_paddr != p_addr ||
                             i2c_pwdata != p_wd || i2c_pwrite != p_wr)) viol <= viol + 1;
         else if (i2c_psel && !i2c_penable && p_sel) viol <= viol + 1;
         else if (p_sel && !p_en && !(i2c_psel && i2c_penable)) viol <= viol + 1;
      end
      p_sel  <= i2c_psel;
      p_en   <= i2c_penable;
      p_wr   <= i2c_pwrite;
      p_addr <= i2c_paddr;
      p_wd   <= i2c_pwdata;
   end

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic fill_rom(input bit allow_dly);
      for (int e = 0; e < 16; e++) begin
         rom[e] = {8'($urandom_range(254, 0)), 8'($urandom)};
         if (allow_dly && $urandom_range(5, 0) == 0) rom[e] = {8'hFF, 8'($urandom_range(3, 0))};
      end
   endtask

   // Expected APB writes and the status script, entry by entry and byte by byte
   task automatic model(input int bad_at, input int bad_code);
      int trig = 0;
      logic [7:0] good, tx;
      exp_q.delete();
      st_q.delete();
      m_err = 1'b0; m_est = 8'h00; m_done = 1'b0; m_idx = 0;
      exp_q.push_back({9'h000, 8'h40});
      for (int e = 0; e < N; e++) begin
         m_idx = e;
         if (rom[e][15:8] == 8'hFF) continue;
         exp_q.push_back(W_STA);
         for (int b = 0; b < 4; b++) begin
            if (b > 0) begin
               tx = b == 1 ? 8'h42 : b == 2 ? rom[e][15:8] : rom[e][7:0];
               exp_q.push_back({9'h008, tx});
               exp_q.push_back({9'h000, 8'h40});
            end
            if (trig == bad_at) begin
               st_q.push_back(bad_code);
               m_err = 1'b1;
               m_est = bad_code < 0 ? 8'hEE : 8'(bad_code);
               if (bad_code != 32'h38) exp_q.push_back(W_STOP);
               return;
            end
            good = b == 0 ? ($urandom_range(1, 0) != 0 ? 8'h08 : 8'h10) : b == 1 ? 8'h18 : 8'h28;
            st_q.push_back(int'(good));
            trig++;
         end
         exp_q.push_back(W_STOP);
      end
      m_done = 1'b1;
   endtask

   task automatic run(input int bad_at, input int bad_code);
      int d0, v0;
      model(bad_at, bad_code);
      log_base = log_q.size();
      d0 = dones;
      v0 = viol;
      start = 1'b1;
      @(negedge PCLK);
      start = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         @(negedge PCLK);
         start = (i == 40) && busy;
         if (!busy) break;
      end
      check_eq("run_finished", busy, 0);
      if (done) begin
         start = 1'b1;
         @(negedge PCLK);
         start = 1'b0;
         check_eq("start_on_done", busy, 0);
      end
      repeat (3) @(negedge PCLK);
      check_eq("wr_count", log_q.size() - log_base, exp_q.size());
      for (int i = 0; i < exp_q.size() && log_base + i < log_q.size(); i++)
         check_eq("apb_wr", log_q[log_base + i].w, exp_q[i]);
      check_eq("done_pulses", dones - d0, m_done);
      check_eq("error", error, m_err);
      check_eq("err_status", err_status, m_est);
      check_eq("entry_idx", entry_idx, m_idx);
      check_eq("status_left", st_q.size(), 0);
      check_eq("apb_proto", viol - v0, 0);
   endtask

   function automatic int stop_to_start(input int base);
      int c1 = -1;
      for (int i = base; i < log_q.size(); i++) begin
         if (c1 < 0 && log_q[i].w == W_STOP) c1 = log_q[i].cyc;
         else if (c1 >= 0 && log_q[i].w == W_STA) return log_q[i].cyc - c1;
      end
      return -1;
   endfunction

   function automatic int n_stops(input int base);
      int n = 0;
      for (int i = base; i < log_q.size(); i++) if (log_q[i].w == W_STOP) n++;
      return n;
   endfunction

   initial begin
      int g0, g2, n, code;
      bit found;
      fill_rom(1'b0);
      repeat (3) @(negedge PCLK);
      check_eq("reset_outputs", {busy, done, error, err_status, entry_idx, rom_addr, i2c_psel,
                                 i2c_penable, i2c_pwrite, i2c_paddr, i2c_pwdata}, 0);
      PRESETN = 1'b1;
      @(negedge PCLK);
      rom[0] = 16'h1280;
      run(-1, 0);
      rom[1] = 16'hFF00;
      run(-1, 0);
      g0 = stop_to_start(log_base);
      rom[1] = 16'hFF02;
      run(-1, 0);
      g2 = stop_to_start(log_base);
      check_eq("delay_extra", g2 - g0, 2 * CPM);
      fill_rom(1'b0);
      run(11, 32'h30);
      run(-1, 0);
      run(5, 32'h38);
      run(6, -1);
      n = log_q.size();
      check_eq("tmo_window", (log_q[n-1].cyc - log_q[n-2].cyc >= TMO) &&
                             (log_q[n-1].cyc - log_q[n-2].cyc <= TMO + 6), 1);
      model(-1, 0);
      log_base = log_q.size();
      found = 1'b0;
      start = 1'b1;
      @(negedge PCLK);
      start = 1'b0;
      for (int i = 0; i < 5000 && !found; i++) begin
         @(negedge PCLK);
         found = i2c_psel && !i2c_penable && i2c_paddr == 9'h008 && n_stops(log_base) == 3;
      end
      check_eq("rst_trigger_found", found, 1);
      PRESETN = 1'b0;
      @(negedge PCLK);
      check_eq("rst_mid_outputs", {busy, done, error, err_status, entry_idx, rom_addr, i2c_psel,
                                   i2c_penable, i2c_pwrite, i2c_paddr, i2c_pwdata}, 0);
      @(negedge PCLK);
      PRESETN = 1'b1;
      @(negedge PCLK);
      run(-1, 0);
      for (int r = 0; r < 10; r++) begin
         fill_rom(1'b1);
         code = codes[$urandom_range(6, 0)];
         run($urandom_range(1, 0) != 0 ? -1 : int'($urandom_range(31, 0)), code);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/sccb_init_sequencer.md
Name: sccb_init_sequencer

Overview:
- APB master that programs the camera sensor over SCCB through the COREI2C instance it drives.
- Walks a table of {register, value} byte pairs from a synchronous ROM.
- Performs each entry as a 3-phase SCCB write: START, SLA+W, reg, value, STOP.
- Services the core's SI/INT handshake, checks status codes, and supports in-table millisecond delays.

Parameters:
- NUM_ENTRIES, 64, number of table entries processed (1..2^ADDR_W).
- ADDR_W, 8, ROM address width.
- SLAVE_ADDR, 8'h42, 8-bit SLA+W byte sent after START.
- CR_SEL, 3'b000, COREI2C clock-rate bits {CR2,CR1,CR0} placed into CTRL bits 7,1,0.
- CYCLES_PER_MS, 30000, PCLK cycles per millisecond (30 MHz).
- INT_TIMEOUT, 65535, maximum PCLK cycles to wait for i2c_int before aborting.
- STOP_GAP, 300, idle PCLK cycles after issuing STOP before the next START.
- IGNORE_NACK, 1, 1 = treat status 0x20/0x30 as success (SCCB don't-care bit).

Ports:
- PCLK  in  1  clock.
- PRESETN  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins the table walk when idle, ignored when busy.
- rom_addr  out  ADDR_W  table index; rom_data is valid one cycle later.
- rom_data  in  16  {reg[15:8], value[7:0]}.
- i2c_psel  out  1  APB select to COREI2C.
- i2c_penable  out  1  APB enable.
- i2c_pwrite  out  1  APB direction, 1 = write.
- i2c_paddr  out  9  APB address.
- i2c_pwdata  out  8  APB write data.
- i2c_prdata  in  8  APB read data.
- i2c_int  in  1  COREI2C SI interrupt, level.
- busy  out  1  high from accepted start until done/error.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky; cleared by the next accepted start.
- err_status  out  8  status byte that caused the abort; 8'hEE = INT timeout.
- entry_idx  out  ADDR_W  index of the current (or failing) entry.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE.
- Reset is sampled on the PCLK edge and aborts any transfer mid-operation with no STOP issued; the bus is recovered by the core's own reset.
- COREI2C register map: CTRL 0x000, STATUS 0x004, DATA 0x008.
- CTRL bits: CR2 b7, ENS1 b6, STA b5, STO b4, SI b3, AA b2, CR1 b1, CR0 b0.
- BASE = ENS1 | CR bits, with AA=0.
- APB access takes exactly 2 cycles, because the core has no PREADY:
  - setup: psel=1, penable=0, with address, data and pwrite valid;
  - access: psel=1, penable=1.
  - Read data is captured at the end of the access cycle.
  - psel is deasserted between transfers (minimum 1 idle cycle).
- FSM states, in order:
  - IDLE;
  - ENABLE: write CTRL=BASE;
  - FETCH: drive rom_addr=entry_idx, wait 1 cycle, latch reg/value;
  - DELAY: taken when reg==8'hFF; wait value*CYCLES_PER_MS cycles; value 0 means no wait;
  - START: write CTRL=BASE|STA;
  - WAIT_INT, then read STATUS and CHECK;
  - per byte, in order SLAVE_ADDR, reg, value: write DATA, then write CTRL=BASE to clear SI and STA; then WAIT_INT, read STATUS, CHECK;
  - STOP: write CTRL=BASE|STO;
  - GAP: wait STOP_GAP cycles;
  - NEXT.
- Expected status codes:
  - after START: 0x08, or 0x10 for a repeated start;
  - after SLA+W: 0x18 (0x20 accepted only if IGNORE_NACK);
  - after each data byte: 0x28 (0x30 accepted only if IGNORE_NACK).
- Any other status code:
  - latch err_status and set error;
  - write CTRL=BASE|STO, except on 0x38 (arbitration lost), where STO is not written and the FSM goes straight to IDLE;
  - return to IDLE with busy=0 and no done pulse.
- WAIT_INT counter:
  - reset on entry to WAIT_INT;
  - if it reaches INT_TIMEOUT without i2c_int: err_status=8'hEE, then STOP write and abort as above.
- NEXT:
  - if entry_idx==NUM_ENTRIES-1: pulse done, busy=0, entry_idx holds the last index;
  - else increment entry_idx and go to FETCH. No wrap beyond NUM_ENTRIES.
- A start pulse arriving while busy has no effect.
- A start pulse in the same cycle as done is ignored.
- The delay counter is wide enough for 255*CYCLES_PER_MS with no overflow.

Test Plan:
- Single entry {0x12,0x80}, NUM_ENTRIES=1, core model returns 0x08/0x18/0x28/0x28 → APB writes in order: CTRL=0x40, CTRL=0x60, DATA=0x42, CTRL=0x40, DATA=0x12, CTRL=0x40, DATA=0x80, CTRL=0x40, CTRL=0x50; then done pulse; 2-cycle setup/access on each transfer.
- Entry {0xFF,0x02} between two writes, CYCLES_PER_MS=10 → exactly 20 cycles with no APB activity before the next START write.
- Status 0x30 on the value byte, IGNORE_NACK=0 → error=1, err_status=0x30, CTRL=0x50 written, entry_idx at the failing entry, no done.
- Same stimulus with IGNORE_NACK=1 → sequence completes, done pulses, error=0.
- i2c_int held low, INT_TIMEOUT=100 → after 100 cycles err_status=0xEE, STOP written, busy=0.
- PRESETN=0 during the DATA write of entry 3 → next edge: all outputs 0, IDLE; a new start restarts at entry 0 with error cleared.
